// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 (CPOL=0, CPHA=0) responder clocked entirely by the system clock.
// Ports:
//   i_clk        system clock, all logic on its rising edge
//   i_reset      asynchronous active-high reset
//   i_cs         chip select from the master, active low, asynchronous
//   i_sck        SPI clock from the master, asynchronous
//   i_mosi       master-out data, asynchronous
//   o_miso       slave-out data, MSB first, 0 whenever no frame is active
//   i_tx_bytes   response word, captured when a frame starts
//   o_rx_bytes   last correctly sized received word, held between frames
//   o_rx_valid   one-clock pulse when o_rx_bytes updates
//   o_frame_err  one-clock pulse when a frame ends with the wrong bit count
//   o_busy       high while a frame is active
module spi_slave #(
    parameter int FRAME_BITS = 40,
    parameter int CNT_W      = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cs,
    input  logic                  i_sck,
    input  logic                  i_mosi,
    output logic                  o_miso,
    input  logic [FRAME_BITS-1:0] i_tx_bytes,
    output logic [FRAME_BITS-1:0] o_rx_bytes,
    output logic                  o_rx_valid,
    output logic                  o_frame_err,
    output logic                  o_busy
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(FRAME_BITS + 1);

    state_t                r_state;
    logic                  r_cs_m, r_cs_s, r_cs_d;
    logic                  r_sck_m, r_sck_s, r_sck_d;
    logic                  r_mosi_m, r_mosi_s;
    logic [FRAME_BITS-1:0] r_tx_sr, r_rx_sr, r_rx_bytes;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_rx_valid, r_frame_err;

    logic w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall;

    assign w_cs_fall  = !r_cs_s &&  r_cs_d;
    assign w_cs_rise  =  r_cs_s && !r_cs_d;
    assign w_sck_rise =  r_sck_s && !r_sck_d;
    assign w_sck_fall = !r_sck_s &&  r_sck_d;

    // The cs chain resets low, so cs held low across reset release never looks like a fall.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cs_m      <= 1'b0;
            r_cs_s      <= 1'b0;
            r_cs_d      <= 1'b0;
            r_sck_m     <= 1'b0;
            r_sck_s     <= 1'b0;
            r_sck_d     <= 1'b0;
            r_mosi_m    <= 1'b0;
            r_mosi_s    <= 1'b0;
            r_state     <= IDLE;
            r_tx_sr     <= '0;
            r_rx_sr     <= '0;
            r_bit_cnt   <= '0;
            r_rx_bytes  <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_cs_m      <= i_cs;
            r_cs_s      <= r_cs_m;
            r_cs_d      <= r_cs_s;
            r_sck_m     <= i_sck;
            r_sck_s     <= r_sck_m;
            r_sck_d     <= r_sck_s;
            r_mosi_m    <= i_mosi;
            r_mosi_s    <= r_mosi_m;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_state == IDLE) begin
                if (w_cs_fall) begin
                    r_tx_sr   <= i_tx_bytes;
                    r_rx_sr   <= '0;
                    r_bit_cnt <= '0;
                    r_state   <= ACTIVE;
                end
            end else if (w_cs_rise) begin
                // End of frame wins over any sck edge seen in the same cycle.
                if (r_bit_cnt == FULL) begin
                    r_rx_bytes <= r_rx_sr;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_frame_err <= 1'b1;
                end
                r_state <= IDLE;
            end else if (w_sck_rise) begin
                r_rx_sr <= {r_rx_sr[FRAME_BITS-2:0], r_mosi_s};
                // Saturating one past a full frame keeps over-long frames flagged as errors.
                if (r_bit_cnt != SAT) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end else if (w_sck_fall) begin
                r_tx_sr <= {r_tx_sr[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    assign o_miso      = (r_state == ACTIVE) && r_tx_sr[FRAME_BITS-1];
    assign o_busy      = (r_state == ACTIVE);
    assign o_rx_bytes  = r_rx_bytes;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;
endmodule
